// File: rtl/iis_clk_gen_if.sv
// Configuration handshake bundle for the audio clock generator.
// The master offers divider/mode settings and the generator accepts them via cfg_ready.
interface iis_clk_gen_if #(
  parameter int DIV_W = 8
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [DIV_W-1:0] cfg_mclk_div;
  logic [DIV_W-1:0] cfg_bclk_div;
  logic             cfg_mode;

  modport master (
    output cfg_valid, cfg_mclk_div, cfg_bclk_div, cfg_mode,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_mclk_div, cfg_bclk_div, cfg_mode,
    output cfg_ready
  );
endinterface

// File: rtl/iis_clk_gen.sv
// I2S/TDM clock generator: derives mclk, bclk and lrck from clkin once the PLL is locked,
// with glitch-free divider/mode changes applied at frame boundaries.
module iis_clk_gen #(
  parameter int DIV_W        = 8,
  parameter int SLOT_W       = 32,
  parameter int CHANNELS     = 2,
  parameter int LOCK_CNT     = 1024,
  parameter int MCLK_DIV_RST = 4,
  parameter int BCLK_DIV_RST = 16
) (
  input  logic         clkin,
  input  logic         reset,
  input  logic         pll_lock,
  iis_clk_gen_if.slave cfg,
  output logic         mclk,
  output logic         bclk,
  output logic         lrck,
  output logic         bclk_fall_stb,
  output logic         frame_stb,
  output logic         clk_ok
);

  localparam int FRAME_LEN = CHANNELS * SLOT_W;
  localparam int FCW       = $clog2(FRAME_LEN);
  localparam int LCW       = $clog2(LOCK_CNT + 1);
  localparam logic [FCW-1:0] FRAME_LAST = FCW'(FRAME_LEN - 1);
  localparam logic [FCW-1:0] FRAME_HALF = FCW'(FRAME_LEN / 2);
  localparam logic [LCW-1:0] LOCK_LAST  = LCW'(LOCK_CNT - 1);

  typedef enum logic [1:0] {
    S_WAIT_LOCK = 2'd0,
    S_RUN       = 2'd1,
    S_SWITCH    = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;

  logic             r_lock_meta;
  logic             r_lock_sync;
  logic [LCW-1:0]   r_lock_cnt;

  logic [DIV_W-1:0] r_act_mdiv;
  logic [DIV_W-1:0] r_act_bdiv;
  logic             r_act_mode;
  logic [DIV_W-1:0] r_pend_mdiv;
  logic [DIV_W-1:0] r_pend_bdiv;
  logic             r_pend_mode;
  logic             r_cfg_pending;
  logic             r_cfg_ready;

  logic [DIV_W-1:0] r_mclk_cnt;
  logic [DIV_W-1:0] r_bclk_cnt;
  logic [FCW-1:0]   r_frame_cnt;
  logic             r_mclk;
  logic             r_bclk;
  logic             r_lrck;
  logic             r_fall_stb;
  logic             r_frame_stb;
  logic             r_clk_ok;

  logic [DIV_W-1:0] w_mdiv_m1;
  logic [DIV_W-1:0] w_bdiv_m1;
  logic             w_active;
  logic             w_active_next;
  logic             w_mclk_tick;
  logic             w_bclk_tick;
  logic             w_bclk_fall;
  logic             w_wrap;
  logic             w_capture;
  logic             w_apply;
  logic             w_mode_next;

  logic [DIV_W-1:0] w_mclk_cnt_next;
  logic [DIV_W-1:0] w_bclk_cnt_next;
  logic [FCW-1:0]   w_frame_cnt_next;
  logic             w_mclk_next;
  logic             w_bclk_next;
  logic             w_lrck_next;
  logic             w_fall_stb_next;
  logic             w_frame_stb_next;

  // A divider value of 0 behaves as 1, so terminal count is max(div,1)-1.
  assign w_mdiv_m1   = (r_act_mdiv == '0) ? '0 : r_act_mdiv - 1'b1;
  assign w_bdiv_m1   = (r_act_bdiv == '0) ? '0 : r_act_bdiv - 1'b1;
  assign w_active      = (r_state != S_WAIT_LOCK);
  assign w_active_next = (w_state_next != S_WAIT_LOCK);
  assign w_mclk_tick = (r_mclk_cnt == w_mdiv_m1);
  assign w_bclk_tick = (r_bclk_cnt == w_bdiv_m1);
  assign w_bclk_fall = w_active && w_bclk_tick && r_bclk;
  assign w_wrap      = w_bclk_fall && (r_frame_cnt == FRAME_LAST);
  assign w_capture   = cfg.cfg_valid && r_cfg_ready;
  // Pending config lands in WAIT_LOCK, at the frame wrap in SWITCH, or when lock drops in SWITCH.
  assign w_apply     = r_cfg_pending &&
                       ((r_state == S_WAIT_LOCK) ||
                        ((r_state == S_SWITCH) && (w_wrap || !r_lock_sync)));
  assign w_mode_next = w_apply ? r_pend_mode : r_act_mode;

  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      r_state <= S_WAIT_LOCK;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (!r_lock_sync) begin
      w_state_next = S_WAIT_LOCK;
    end else begin
      case (r_state)
        S_WAIT_LOCK: if (r_lock_cnt == LOCK_LAST) w_state_next = S_RUN;
        S_RUN:       if (r_cfg_pending) w_state_next = S_SWITCH;
        S_SWITCH:    if (w_wrap) w_state_next = S_RUN;
        default:     w_state_next = S_WAIT_LOCK;
      endcase
    end
  end

  always_comb begin
    w_mclk_cnt_next  = '0;
    w_bclk_cnt_next  = '0;
    w_frame_cnt_next = '0;
    w_mclk_next      = 1'b0;
    w_bclk_next      = 1'b0;
    w_fall_stb_next  = 1'b0;
    w_frame_stb_next = 1'b0;
    if (w_active && w_active_next) begin
      w_mclk_cnt_next  = w_mclk_tick ? '0 : r_mclk_cnt + 1'b1;
      w_mclk_next      = r_mclk ^ w_mclk_tick;
      w_bclk_cnt_next  = w_bclk_tick ? '0 : r_bclk_cnt + 1'b1;
      w_bclk_next      = r_bclk ^ w_bclk_tick;
      w_frame_cnt_next = r_frame_cnt;
      if (w_bclk_fall) begin
        w_fall_stb_next  = 1'b1;
        w_frame_stb_next = w_wrap;
        w_frame_cnt_next = w_wrap ? '0 : r_frame_cnt + 1'b1;
      end
      // New dividers restart from a clean low phase at the frame boundary.
      if (w_apply) begin
        w_mclk_cnt_next = '0;
        w_mclk_next     = 1'b0;
      end
    end
    w_lrck_next = w_active_next &&
                  (w_mode_next ? (w_frame_cnt_next == '0) : (w_frame_cnt_next >= FRAME_HALF));
  end

  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      r_lock_meta   <= 1'b0;
      r_lock_sync   <= 1'b0;
      r_lock_cnt    <= '0;
      r_act_mdiv    <= DIV_W'(MCLK_DIV_RST);
      r_act_bdiv    <= DIV_W'(BCLK_DIV_RST);
      r_act_mode    <= 1'b0;
      r_pend_mdiv   <= '0;
      r_pend_bdiv   <= '0;
      r_pend_mode   <= 1'b0;
      r_cfg_pending <= 1'b0;
      r_cfg_ready   <= 1'b1;
      r_mclk_cnt    <= '0;
      r_bclk_cnt    <= '0;
      r_frame_cnt   <= '0;
      r_mclk        <= 1'b0;
      r_bclk        <= 1'b0;
      r_lrck        <= 1'b0;
      r_fall_stb    <= 1'b0;
      r_frame_stb   <= 1'b0;
      r_clk_ok      <= 1'b0;
    end else begin
      r_lock_meta <= pll_lock;
      r_lock_sync <= r_lock_meta;
      if ((r_state == S_WAIT_LOCK) && (w_state_next == S_WAIT_LOCK) && r_lock_sync) begin
        r_lock_cnt <= r_lock_cnt + 1'b1;
      end else begin
        r_lock_cnt <= '0;
      end

      // cfg_ready lags the pending flag by one cycle on release.
      if (w_capture) begin
        r_pend_mdiv   <= cfg.cfg_mclk_div;
        r_pend_bdiv   <= cfg.cfg_bclk_div;
        r_pend_mode   <= cfg.cfg_mode;
        r_cfg_pending <= 1'b1;
        r_cfg_ready   <= 1'b0;
      end else begin
        if (w_apply) r_cfg_pending <= 1'b0;
        r_cfg_ready <= !r_cfg_pending;
      end
      if (w_apply) begin
        r_act_mdiv <= r_pend_mdiv;
        r_act_bdiv <= r_pend_bdiv;
        r_act_mode <= r_pend_mode;
      end

      r_mclk_cnt  <= w_mclk_cnt_next;
      r_bclk_cnt  <= w_bclk_cnt_next;
      r_frame_cnt <= w_frame_cnt_next;
      r_mclk      <= w_mclk_next;
      r_bclk      <= w_bclk_next;
      r_lrck      <= w_lrck_next;
      r_fall_stb  <= w_fall_stb_next;
      r_frame_stb <= w_frame_stb_next;
      r_clk_ok    <= w_active_next;
    end
  end

  assign cfg.cfg_ready  = r_cfg_ready;
  assign mclk           = r_mclk;
  assign bclk           = r_bclk;
  assign lrck           = r_lrck;
  assign bclk_fall_stb  = r_fall_stb;
  assign frame_stb      = r_frame_stb;
  assign clk_ok         = r_clk_ok;

endmodule

// File: tb/tb_iis_clk_gen.sv
// Directed bench for iis_clk_gen: default-parameter instance plus an 8-channel TDM instance
// sharing clock, reset and PLL lock.
module tb_iis_clk_gen;

  logic clk = 1'b0;
  logic rst;
  logic lock;

  iis_clk_gen_if #(.DIV_W(8)) ifa ();
  iis_clk_gen_if #(.DIV_W(8)) ifb ();

  logic a_mclk, a_bclk, a_lrck, a_fall, a_fstb, a_ok;
  logic b_mclk, b_bclk, b_lrck, b_fall, b_fstb, b_ok;

  iis_clk_gen #(.DIV_W(8)) dut_a (
    .clkin(clk), .reset(rst), .pll_lock(lock), .cfg(ifa),
    .mclk(a_mclk), .bclk(a_bclk), .lrck(a_lrck),
    .bclk_fall_stb(a_fall), .frame_stb(a_fstb), .clk_ok(a_ok)
  );

  iis_clk_gen #(.DIV_W(8), .CHANNELS(8), .SLOT_W(32)) dut_b (
    .clkin(clk), .reset(rst), .pll_lock(lock), .cfg(ifb),
    .mclk(b_mclk), .bclk(b_bclk), .lrck(b_lrck),
    .bclk_fall_stb(b_fall), .frame_stb(b_fstb), .clk_ok(b_ok)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  int   m_first, m_rises, m_high, b_first, b_rises, f_cnt, l_first, l_second, l_high;
  int   fs_first, fs_cnt, bl_high, bf_cnt;
  logic pm, pb, pl;

  initial begin
    rst = 1'b1;
    lock = 1'b1;
    ifa.cfg_valid = 1'b0; ifa.cfg_mclk_div = '0; ifa.cfg_bclk_div = '0; ifa.cfg_mode = 1'b0;
    ifb.cfg_valid = 1'b0; ifb.cfg_mclk_div = '0; ifb.cfg_bclk_div = '0; ifb.cfg_mode = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_outputs", {a_mclk, a_bclk, a_lrck, a_fall, a_fstb, a_ok}, 0);
    chk("rst_cfg_ready", ifa.cfg_ready, 1);
    rst = 1'b0;

    // Lock held from reset: clk_ok after 2 sync + LOCK_CNT cycles; TDM instance configured in WAIT_LOCK.
    for (int k = 1; k <= 1026; k++) begin
      @(negedge clk);
      if (k == 1) begin
        chk("first_cycle_quiet", {a_mclk, a_bclk, a_lrck, a_fall, a_fstb, a_ok}, 0);
        ifb.cfg_valid = 1'b1; ifb.cfg_mclk_div = 8'd1; ifb.cfg_bclk_div = 8'd1; ifb.cfg_mode = 1'b1;
      end
      if (k == 2) begin
        ifb.cfg_valid = 1'b0;
        chk("b_ready_low", ifb.cfg_ready, 0);
      end
      if (k == 4)    chk("b_ready_back", ifb.cfg_ready, 1);
      if (k == 1025) chk("clk_ok_early", a_ok, 0);
    end
    chk("a_clk_ok_rise", a_ok, 1);
    chk("b_clk_ok_rise", b_ok, 1);

    // Default-config waveform census over the first frame and a half.
    m_first = -1; m_rises = 0; m_high = 0; b_first = -1; b_rises = 0; f_cnt = 0;
    l_first = -1; l_second = -1; l_high = 0; fs_first = -1; fs_cnt = 0; bl_high = 0; bf_cnt = 0;
    pm = a_mclk; pb = a_bclk; pl = a_lrck;
    for (int k = 1; k <= 3072; k++) begin
      @(negedge clk);
      if (k <= 2048) begin
        if (a_mclk && !pm) begin m_rises++; if (m_first < 0) m_first = k; end
        if (a_mclk) m_high++;
        if (a_bclk && !pb) begin b_rises++; if (b_first < 0) b_first = k; end
        if (a_fall) f_cnt++;
        if (a_lrck) l_high++;
        if (a_fstb) begin fs_cnt++; if (fs_first < 0) fs_first = k; end
      end
      if (a_lrck && !pl) begin
        if (l_first < 0) l_first = k; else if (l_second < 0) l_second = k;
      end
      pm = a_mclk; pb = a_bclk; pl = a_lrck;
      if (k >= 3 && k <= 1026) begin
        if (b_lrck) bl_high++;
        if (b_fstb) bf_cnt++;
      end
      if (k == 511) chk("tdm_lrck_before", b_lrck, 0);
      if (k == 512) chk("tdm_lrck_stb", {b_lrck, b_fstb}, 2'b11);
      if (k == 513) chk("tdm_lrck_hold", {b_lrck, b_fstb}, 2'b10);
      if (k == 514) chk("tdm_lrck_after", b_lrck, 0);
    end
    chk("mclk_first_rise", m_first, 4);
    chk("mclk_rises", m_rises, 256);
    chk("mclk_duty", m_high, 1024);
    chk("bclk_first_rise", b_first, 16);
    chk("bclk_rises", b_rises, 64);
    chk("bclk_fall_stbs", f_cnt, 64);
    chk("lrck_first_rise", l_first, 1024);
    chk("lrck_period", l_second - l_first, 2048);
    chk("lrck_duty", l_high, 1024);
    chk("frame_stb_first", fs_first, 2048);
    chk("frame_stb_count", fs_cnt, 1);
    chk("tdm_lrck_high", bl_high, 4);
    chk("tdm_frame_stbs", bf_cnt, 2);

    // Mid-frame reconfiguration to bclk_div=8; a second request while busy must be ignored.
    ifa.cfg_valid = 1'b1; ifa.cfg_mclk_div = 8'd4; ifa.cfg_bclk_div = 8'd8; ifa.cfg_mode = 1'b0;
    for (int k = 3073; k <= 4130; k++) begin
      @(negedge clk);
      if (k == 3073) begin
        ifa.cfg_valid = 1'b0;
        chk("sw_ready_low", ifa.cfg_ready, 0);
      end
      if (k == 3500) begin
        chk("sw_busy", ifa.cfg_ready, 0);
        ifa.cfg_valid = 1'b1; ifa.cfg_mclk_div = 8'd1; ifa.cfg_bclk_div = 8'd2; ifa.cfg_mode = 1'b1;
      end
      if (k == 3501) ifa.cfg_valid = 1'b0;
      if (k == 4095) chk("sw_old_bclk", {a_bclk, a_fstb}, 2'b10);
      if (k == 4096) begin
        chk("sw_frame_edge", {a_bclk, a_fall, a_fstb, a_lrck}, 4'b0110);
        chk("sw_ready_still_low", ifa.cfg_ready, 0);
      end
      if (k == 4097) chk("sw_ready_back", ifa.cfg_ready, 1);
      if (k == 4099) chk("sw_mclk_low", a_mclk, 0);
      if (k == 4100) chk("sw_mclk_rise", a_mclk, 1);
      if (k == 4103) chk("sw_bclk_low", a_bclk, 0);
      if (k == 4104) chk("sw_bclk_rise", a_bclk, 1);
      if (k == 4111) chk("sw_bclk_high", a_bclk, 1);
      if (k == 4112) chk("sw_bclk_fall", {a_bclk, a_fall}, 2'b01);
      if (k == 4120) chk("sw_bclk_rise2", a_bclk, 1);
      if (k == 4128) chk("sw_bclk_fall2", {a_bclk, a_fall}, 2'b01);
    end

    // Lock loss mid-frame, then a zero mclk divider written while waiting for lock.
    lock = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 2) chk("lock_loss_lag", a_ok, 1);
      if (k == 3) begin
        chk("lock_loss_quiet", {a_mclk, a_bclk, a_lrck, a_fall, a_fstb, a_ok}, 0);
        chk("lock_loss_b", b_ok, 0);
      end
      if (k == 5) begin
        ifa.cfg_valid = 1'b1; ifa.cfg_mclk_div = 8'd0; ifa.cfg_bclk_div = 8'd8; ifa.cfg_mode = 1'b0;
      end
      if (k == 6) ifa.cfg_valid = 1'b0;
      if (k == 8) chk("wait_cfg_ready", ifa.cfg_ready, 1);
    end

    // Relock with a one-cycle glitch at lock count 500, then async reset while running.
    lock = 1'b1;
    for (int j = 1; j <= 1540; j++) begin
      @(negedge clk);
      if (j == 502) lock = 1'b0;
      if (j == 503) lock = 1'b1;
      if (j == 1000) chk("glitch_quiet", {a_mclk, a_bclk, a_lrck, a_ok}, 0);
      if (j == 1528) chk("glitch_clk_ok_early", a_ok, 0);
      if (j == 1529) chk("glitch_clk_ok", {a_ok, a_mclk}, 2'b10);
      if (j == 1530) chk("mclk_div0_a", a_mclk, 1);
      if (j == 1531) chk("mclk_div0_b", a_mclk, 0);
      if (j == 1532) chk("mclk_div0_c", a_mclk, 1);
      if (j == 1536) chk("relock_bclk_low", a_bclk, 0);
      if (j == 1537) chk("relock_bclk_rise", a_bclk, 1);
    end
    chk("pre_async_rst", {a_bclk, a_ok}, 2'b11);
    #3 rst = 1'b1;
    #1;
    chk("async_rst_quiet", {a_mclk, a_bclk, a_lrck, a_fall, a_fstb, a_ok}, 0);
    chk("async_rst_ready", ifa.cfg_ready, 1);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // After reset the default dividers are back in force.
    for (int k = 1; k <= 1030; k++) begin
      @(negedge clk);
      if (k == 1025) chk("rerun_clk_ok_early", a_ok, 0);
      if (k == 1026) chk("rerun_clk_ok", a_ok, 1);
      if (k == 1029) chk("rerun_mclk_low", a_mclk, 0);
      if (k == 1030) chk("rerun_mclk_rise", a_mclk, 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/iis_clk_gen.md
IIS_CLK_GEN -- requirements
Module: iis_clk_gen

Interface
REQ-001 SHALL have parameter DIV_W, default 8: width of divider config fields.
REQ-002 SHALL have parameter SLOT_W, default 32: bclk periods per channel slot, range 8..32.
REQ-003 SHALL have parameter CHANNELS, default 2: slots per frame, range 2..8.
REQ-004 SHALL have parameter LOCK_CNT, default 1024: consecutive synced-lock cycles required before running.
REQ-005 SHALL have parameters MCLK_DIV_RST, default 4, and BCLK_DIV_RST, default 16: active half-period values after reset.
REQ-006 SHALL have port clkin  in  1: master clock, nominally 98.304 MHz from the PLL; all logic is on its rising edge.
REQ-007 SHALL have port reset  in  1: asynchronous, active-high reset.
REQ-008 SHALL have port pll_lock  in  1: PLL lock, asynchronous to clkin.
REQ-009 SHALL have ports cfg_valid in 1, cfg_ready out 1: config handshake.
REQ-010 SHALL have ports cfg_mclk_div in DIV_W and cfg_bclk_div in DIV_W: half-periods in clkin cycles.
REQ-011 SHALL have port cfg_mode  in  1: 0 = I2S 50% lrck, 1 = TDM one-bclk frame pulse.
REQ-012 SHALL have ports mclk, bclk, lrck  out 1 each: registered audio clocks.
REQ-013 SHALL have ports bclk_fall_stb, frame_stb  out 1 each: one-clkin strobes.
REQ-014 SHALL have port clk_ok  out 1: high while in RUN.

Function
REQ-015 SHALL synchronise pll_lock through 2 flops before any use.
REQ-016 SHALL implement FSM WAIT_LOCK -> RUN -> (SWITCH -> RUN); a synced-lock low in any state SHALL go to WAIT_LOCK.
REQ-017 In WAIT_LOCK, SHALL count consecutive synced-lock-high cycles, restart at 0 on any low, and enter RUN when the count reaches LOCK_CNT.
REQ-018 Outside RUN/SWITCH, mclk, bclk, lrck, strobes and clk_ok SHALL be 0 and all divider/frame counters held at 0.
REQ-019 mclk SHALL toggle every max(mclk_div,1) clkin cycles; bclk SHALL toggle every max(bclk_div,1) cycles; a div value of 0 SHALL be treated as 1.
REQ-020 First mclk and bclk rising edges SHALL occur exactly div cycles after entering RUN.
REQ-021 The frame counter SHALL advance on each bclk falling edge and wrap at CHANNELS*SLOT_W-1 to 0.
REQ-022 bclk_fall_stb SHALL be high in the clkin cycle in which bclk registers 1->0.
REQ-023 frame_stb SHALL be high in that cycle when the frame counter wraps to 0.
REQ-024 In mode 0, lrck SHALL be 1 for frame count >= CHANNELS*SLOT_W/2 and 0 otherwise, updating on bclk falling edges.
REQ-025 In mode 1, lrck SHALL be 1 only while the frame count = 0.
REQ-026 cfg_ready SHALL be 1 when no config is pending; a cfg_valid&&cfg_ready cycle SHALL capture all three cfg fields and drop cfg_ready next cycle.
REQ-027 Captured config SHALL apply immediately in WAIT_LOCK.
REQ-028 In RUN, a captured config SHALL enter SWITCH and apply in the frame_stb cycle, resetting divider phase, so no bclk/lrck pulse is shorter than the smaller of the old and new half-periods.
REQ-029 cfg_ready SHALL return to 1 the cycle after a config is applied.
REQ-030 cfg_valid while cfg_ready=0 SHALL be ignored.
REQ-031 Lock loss during SWITCH SHALL apply the pending config on entry to WAIT_LOCK.
REQ-032 All outputs SHALL be registered, with no combinational path from inputs to outputs.

Reset
REQ-033 On reset, FSM=WAIT_LOCK, clock and strobe outputs=0, clk_ok=0, cfg_ready=1, active config = MCLK_DIV_RST/BCLK_DIV_RST/mode 0, lock counter=0.
REQ-034 Deassertion of reset SHALL take effect only on a clkin edge; no output SHALL change in the first cycle after deassertion.

Verification
REQ-035 Reset, pll_lock=1 held, defaults -> clk_ok rises 2+1024 cycles later; mclk period 8 cycles (12.288 MHz), bclk period 32, lrck period 2048 (48 kHz), 50% duty.
REQ-036 pll_lock pulsed low for 1 cycle at count 500 -> lock counter restarts; clk_ok delayed accordingly; outputs stay 0.
REQ-037 In RUN, request bclk_div=8 at mid-frame -> cfg_ready=0; old bclk continues to frame_stb; new bclk period 16 thereafter; cfg_ready=1 one cycle after frame_stb.
REQ-038 Mode 1 with CHANNELS=8, SLOT_W=32 -> lrck high for exactly one bclk period every 256 bclk periods, coincident with frame_stb.
REQ-039 Drop pll_lock mid-frame -> all clocks 0 and clk_ok=0 within 3 cycles; cfg_mclk_div=0 written in WAIT_LOCK -> mclk period 2 after relock.
REQ-040 Assert reset asynchronously mid-cycle in RUN -> all outputs 0 immediately, without waiting for a clkin edge.
